// File: rtl/riscv_data_mem.sv
// Word-organised data RAM: synchronous writes, combinational reads and verify tap, async clear; no stalls.
// Optional DATA_MEM_DEBUG_EN compiles in per-access $display tracing.
module riscv_data_mem #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] VERIFY_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [31:0] verify
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES  = 32'(DEPTH * 4);
  localparam logic [AW-1:0] VERIFY_IDX = VERIFY_ADDR[AW+1:2];

  logic [31:0]   mem [DEPTH];
  logic          in_range;
  logic [AW-1:0] idx;
  logic          wr_en;
  logic          rd_en;

  // Full-address compare so addresses above the RAM never alias onto low words
  assign in_range = (addr < MEM_BYTES);
  assign idx      = addr[AW+1:2];
  assign wr_en    = ce && we && in_range;
  assign rd_en    = ce && !we && in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (wr_en) begin
      mem[idx] <= data_i;
    end
  end

  // Reads see the pre-edge contents; there is deliberately no write-through path
  assign data_o = rd_en ? mem[idx] : 32'h0;
  assign verify = mem[VERIFY_IDX];

`ifdef DATA_MEM_DEBUG_EN
  always @(posedge clk) begin
    if (rst && wr_en) begin
      $display("[data_mem] %0t write addr=%h data=%h (%0d)", $time, addr, data_i, data_i);
    end
    if (rst && ce && !we) begin
      $display("[data_mem] %0t read  addr=%h data=%h", $time, addr, data_o);
    end
  end
`endif

endmodule

// File: tb/tb_riscv_data_mem.sv
// Directed table-driven bench for riscv_data_mem plus hand-written read-during-write and async-reset sequences.
module tb_riscv_data_mem;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [31:0] verify;

  int n_tests;
  int n_fail;

  riscv_data_mem dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .we     (we),
    .addr   (addr),
    .data_i (data_i),
    .data_o (data_o),
    .verify (verify)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_dout;    // data_o sampled before the edge
    logic [31:0] exp_verify;  // verify sampled after the edge
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    ce     = c;
    we     = w;
    addr   = a;
    data_i = d;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    vecs[0]  = '{"idle",          1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         32'h0};
    vecs[1]  = '{"wr_dead",       1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         32'h0};
    vecs[2]  = '{"rd_dead",       1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 32'h0};
    vecs[3]  = '{"rd_ce0",        1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         32'h0};
    vecs[4]  = '{"wr_verify42",   1'b1, 1'b1, 32'h0000_0000, 32'd42,        32'h0,         32'd42};
    vecs[5]  = '{"wr_0x20",       1'b1, 1'b1, 32'h0000_0020, 32'd7,         32'h0,         32'd42};
    vecs[6]  = '{"rd_0x20",       1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'd7,         32'd42};
    vecs[7]  = '{"wr_misalign",   1'b1, 1'b1, 32'h0000_0013, 32'h1234_5678, 32'h0,         32'd42};
    vecs[8]  = '{"rd_0x10",       1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h1234_5678, 32'd42};
    vecs[9]  = '{"rd_0x11",       1'b1, 1'b0, 32'h0000_0011, 32'h0,         32'h1234_5678, 32'd42};
    vecs[10] = '{"wr_oor_top",    1'b1, 1'b1, 32'h0000_1000, 32'hAAAA_5555, 32'h0,         32'd42};
    vecs[11] = '{"rd_oor_top",    1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h0,         32'd42};
    vecs[12] = '{"rd_alias0",     1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'd42,        32'd42};
    vecs[13] = '{"wr_last",       1'b1, 1'b1, 32'h0000_0FFC, 32'h0000_0001, 32'h0,         32'd42};
    vecs[14] = '{"rd_last",       1'b1, 1'b0, 32'h0000_0FFE, 32'h0,         32'h0000_0001, 32'd42};
    vecs[15] = '{"wr_oor_high",   1'b1, 1'b1, 32'hFFFF_0010, 32'hBAD0_BAD0, 32'h0,         32'd42};
    vecs[16] = '{"wr_ce0",        1'b0, 1'b1, 32'h0000_0020, 32'd99,        32'h0,         32'd42};
    vecs[17] = '{"rd_0x20_again", 1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'd7,         32'd42};

    // Power-up reset with a real falling edge
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset_verify", verify, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    #1;
    check("reset_rd", data_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].ce, vecs[i].we, vecs[i].addr, vecs[i].din);
      #1;
      check({vecs[i].name, "_dout"}, data_o, vecs[i].exp_dout);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_verify"}, verify, vecs[i].exp_verify);
    end

    // Read-during-write at 0x8: old contents until the edge, new value after
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h0000_0008, 32'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    #1;
    check("rdw_old", data_o, 32'd1);
    drive(1'b1, 1'b1, 32'h0000_0008, 32'd2);
    #1;
    check("rdw_wr_cycle_dout", data_o, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    #1;
    check("rdw_new", data_o, 32'd2);

    // Same thing through the verify tap: no bypass onto verify either
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h0000_0000, 32'd100);
    #1;
    check("rdw_verify_pre", verify, 32'd42);
    @(posedge clk);
    #1;
    check("rdw_verify_post", verify, 32'd100);

    // Async reset falls between edges during a write
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h0000_0010, 32'h5555_5555);
    #1 rst = 1'b0;
    #1;
    check("arst_verify_now", verify, 32'h0);
    drive(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    #1;
    check("arst_rd_now", data_o, 32'h0);
    drive(1'b1, 1'b1, 32'h0000_0010, 32'h5555_5555);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    #1;
    check("arst_wr_ignored", data_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);

    // After release every previously written word must still read 0
    begin
      logic [31:0] probe [5];
      probe[0] = 32'h0000_0000;
      probe[1] = 32'h0000_0008;
      probe[2] = 32'h0000_0010;
      probe[3] = 32'h0000_0020;
      probe[4] = 32'h0000_0FFC;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        drive(1'b1, 1'b0, probe[i], 32'h0);
        #1;
        check($sformatf("post_rst_rd_%h", probe[i]), data_o, 32'h0);
      end
    end
    check("post_rst_verify", verify, 32'h0);

    // Memory usable again after reset
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    #1;
    check("post_rst_wr_rd", data_o, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
